// File: rtl/bist_sched_pkg.sv
// Shared definitions for the BIST CUT scheduler: session state encoding,
// the fixed PREP length and a one-hot to index helper.
package bist_sched_pkg;

    // Session phases, walked in this order for every granted slot
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARB    = 3'd1,
        PREP   = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4,
        REPORT = 3'd5
    } state_t;

    // Cycles the TPG and test path are held in reset before the sweep starts
    localparam int PREP_CYCLES = 2;

    // Returns the position of the set bit of a one-hot vector (0 when empty)
    function automatic int onehot_to_index(input logic [31:0] onehot);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (onehot[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bist_cut_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: starting at the priority pointer, picks
// the first requesting slot, wrapping past the top slot back to slot 0.
module rr_arbiter #(
    parameter int NUM_CUTS = 4,
    parameter int SEL_BITS = 2
) (
    input  logic [NUM_CUTS-1:0] req,
    input  logic [SEL_BITS-1:0] ptr,
    output logic [NUM_CUTS-1:0] grant,
    output logic                valid
);

    // Scan slots in priority order from ptr and keep only the first hit
    always_comb begin
        int                slot_num;
        logic [SEL_BITS-1:0] slot;
        grant    = '0;
        valid    = 1'b0;
        slot_num = 0;
        slot     = '0;
        for (int i = 0; i < NUM_CUTS; i++) begin
            slot_num = int'(ptr) + i;
            if (slot_num >= NUM_CUTS) begin
                slot_num = slot_num - NUM_CUTS;
            end
            slot = SEL_BITS'(slot_num);
            if (!valid && req[slot]) begin
                grant[slot] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bist_cut_scheduler.sv
// Round-robin scheduler that lends one shared TPG + ORA test path to a
// single CUT slot at a time: arbitrate, reset the path, run one sweep,
// drain the ORA pipeline, then report the mismatch count and pass/fail.
// Optional build macro SCHED_TIMEOUT_EN adds a RUN watchdog that ends a
// sweep whose TPG never signals completion and marks the slot as failed.
module bist_cut_scheduler
    import bist_sched_pkg::*;
#(
    parameter int NUM_CUTS = 4,
    parameter int SEL_BITS = 2,
    parameter int ERR_BITS = 5,
    parameter int ORA_LAT  = 2,
    parameter int TO_BITS  = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CUTS-1:0] REQ,
    input  logic                TPG_END,
    input  logic                ORA_RES,
    output logic [NUM_CUTS-1:0] GRANT,
    output logic [SEL_BITS-1:0] CUT_SEL,
    output logic                TPG_RESET,
    output logic                PATH_RST,
    output logic                BUSY,
    output logic                DONE,
    output logic [SEL_BITS-1:0] DONE_ID,
    output logic [ERR_BITS-1:0] ERR_COUNT,
    output logic [NUM_CUTS-1:0] FAIL_MAP
);

    localparam int PREP_W  = (PREP_CYCLES > 1) ? $clog2(PREP_CYCLES) : 1;
    localparam int DRAIN_W = (ORA_LAT > 1) ? $clog2(ORA_LAT) : 1;
    localparam logic [PREP_W-1:0]  PREP_LAST  = PREP_W'(PREP_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(ORA_LAT - 1);
    localparam logic [SEL_BITS-1:0] TOP_SLOT  = SEL_BITS'(NUM_CUTS - 1);

    state_t               state;
    logic [SEL_BITS-1:0]  rr_ptr;
    logic [PREP_W-1:0]    prep_cnt;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [NUM_CUTS-1:0]  win_grant;
    logic                 win_valid;
    logic [SEL_BITS-1:0]  win_idx;
    logic [SEL_BITS-1:0]  next_ptr;
    logic [ERR_BITS-1:0]  err_next;
    logic                 fail_now;

    rr_arbiter #(
        .NUM_CUTS (NUM_CUTS),
        .SEL_BITS (SEL_BITS)
    ) u_arbiter (
        .req   (REQ),
        .ptr   (rr_ptr),
        .grant (win_grant),
        .valid (win_valid)
    );

    assign win_idx  = SEL_BITS'(onehot_to_index(32'(win_grant)));
    assign next_ptr = (win_idx == TOP_SLOT) ? '0 : win_idx + 1'b1;
    assign err_next = (ORA_RES && (ERR_COUNT != '1)) ? ERR_COUNT + 1'b1 : ERR_COUNT;

`ifdef SCHED_TIMEOUT_EN
    // The last watchdog value reached in RUN is one below the full count, so
    // the sweep is abandoned on its (2**TO_BITS-1)-th RUN cycle.
    localparam logic [TO_BITS-1:0] WD_LAST = ~(TO_BITS'(1));

    logic [TO_BITS-1:0] wd_cnt;
    logic               timed_out;

    assign fail_now = (ERR_COUNT != '0) || timed_out;
`else
    assign fail_now = (ERR_COUNT != '0);
`endif

    // Session sequencer: walks IDLE..REPORT and drives every output from a register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            GRANT     <= '0;
            CUT_SEL   <= '0;
            TPG_RESET <= 1'b1;
            PATH_RST  <= 1'b1;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            DONE_ID   <= '0;
            ERR_COUNT <= '0;
            FAIL_MAP  <= '0;
            rr_ptr    <= '0;
            prep_cnt  <= '0;
            drain_cnt <= '0;
`ifdef SCHED_TIMEOUT_EN
            wd_cnt    <= '0;
            timed_out <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|REQ) begin
                        state <= ARB;
                        BUSY  <= 1'b1;
                    end
                end
                ARB: begin
                    if (win_valid) begin
                        state    <= PREP;
                        GRANT    <= win_grant;
                        CUT_SEL  <= win_idx;
                        rr_ptr   <= next_ptr;
                        prep_cnt <= '0;
                    end else begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                PREP: begin
                    ERR_COUNT <= '0;
`ifdef SCHED_TIMEOUT_EN
                    wd_cnt    <= '0;
                    timed_out <= 1'b0;
`endif
                    if (prep_cnt == PREP_LAST) begin
                        state     <= RUN;
                        TPG_RESET <= 1'b0;
                        PATH_RST  <= 1'b0;
                    end else begin
                        prep_cnt <= prep_cnt + 1'b1;
                    end
                end
                RUN: begin
                    ERR_COUNT <= err_next;
                    if (TPG_END) begin
                        state     <= DRAIN;
                        TPG_RESET <= 1'b1;
                        drain_cnt <= '0;
                    end
`ifdef SCHED_TIMEOUT_EN
                    else if (wd_cnt == WD_LAST) begin
                        state     <= DRAIN;
                        TPG_RESET <= 1'b1;
                        drain_cnt <= '0;
                        timed_out <= 1'b1;
                        ERR_COUNT <= '1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                DRAIN: begin
                    ERR_COUNT <= err_next;
                    if (drain_cnt == DRAIN_LAST) begin
                        state    <= REPORT;
                        PATH_RST <= 1'b1;
                        DONE     <= 1'b1;
                        DONE_ID  <= CUT_SEL;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                REPORT: begin
                    if (fail_now) begin
                        FAIL_MAP[CUT_SEL] <= 1'b1;
                    end
                    state <= IDLE;
                    GRANT <= '0;
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_cut_scheduler.sv
// Self-checking bench for bist_cut_scheduler: a session-timeline model
// predicts every output each cycle, and directed scenarios pin the model
// with hand-computed values. Honours SCHED_TIMEOUT_EN like the design.
module tb_bist_cut_scheduler;

    localparam int ORA_LAT = 2;
    localparam int ERR_MAX = 31;
    localparam int WD_RUN  = 127;
`ifdef SCHED_TIMEOUT_EN
    localparam bit HAS_WD = 1'b1;
`else
    localparam bit HAS_WD = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       tpg_end;
    logic       ora_res;
    logic [3:0] grant;
    logic [1:0] cut_sel;
    logic       tpg_reset;
    logic       path_rst;
    logic       busy;
    logic       done;
    logic [1:0] done_id;
    logic [4:0] err_count;
    logic [3:0] fail_map;

    int total;
    int bad;
    int cyc;

    bist_cut_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .REQ       (req),
        .TPG_END   (tpg_end),
        .ORA_RES   (ora_res),
        .GRANT     (grant),
        .CUT_SEL   (cut_sel),
        .TPG_RESET (tpg_reset),
        .PATH_RST  (path_rst),
        .BUSY      (busy),
        .DONE      (done),
        .DONE_ID   (done_id),
        .ERR_COUNT (err_count),
        .FAIL_MAP  (fail_map)
    );

    // 10-time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle stamp used to measure spacing between reports
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: where we are on the session timeline (-1 = idle, 0 = arbitration
    // cycle, then prep, sweep, drain, report), plus the bookkeeping around it
    int         m_t;
    int         m_run_len;
    int         m_win;
    int         m_sel;
    int         m_ptr;
    int         m_err;
    logic [3:0] m_fail;
    bit         m_valid;

    // Advance the model with the inputs seen at this clock edge
    always @(posedge clk) begin
        int pick;
        pick = -1;
        if (rst) begin
            m_valid   = 1'b1;
            m_t       = -1;
            m_run_len = 0;
            m_win     = 0;
            m_sel     = 0;
            m_ptr     = 0;
            m_err     = 0;
            m_fail    = 4'b0000;
        end else if (m_valid) begin
            if (m_t < 0) begin
                if (req != 4'b0000) m_t = 0;
            end else if (m_t == 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (pick < 0 && req[2'((m_ptr + k) % 4)]) pick = (m_ptr + k) % 4;
                end
                if (pick < 0) begin
                    m_t = -1;
                end else begin
                    m_win     = pick;
                    m_sel     = pick;
                    m_ptr     = (pick + 1) % 4;
                    m_err     = 0;
                    m_run_len = 0;
                    m_t       = 1;
                end
            end else if (m_t < 3) begin
                m_t++;
            end else if (m_run_len == 0) begin
                if (ora_res && m_err < ERR_MAX) m_err++;
                if (tpg_end) begin
                    m_run_len = m_t - 2;
                end else if (HAS_WD && (m_t - 2) == WD_RUN) begin
                    m_run_len = WD_RUN;
                    m_err     = ERR_MAX;
                end
                m_t++;
            end else if (m_t < 3 + m_run_len + ORA_LAT) begin
                if (ora_res && m_err < ERR_MAX) m_err++;
                m_t++;
            end else begin
                if (m_err != 0) m_fail[m_win] = 1'b1;
                m_t = -1;
            end
        end
    end

    // Compare every DUT output against the model, away from the active edge
    always @(negedge clk) begin
        int  e_grant;
        bit  e_tpg;
        bit  e_path;
        bit  e_done;
        e_grant = 0;
        e_tpg   = 1'b1;
        e_path  = 1'b1;
        e_done  = 1'b0;
        if (m_valid) begin
            if (m_t >= 1) e_grant = 1 << m_win;
            if (m_t >= 3) begin
                if (m_run_len == 0 || m_t < 3 + m_run_len) begin
                    e_tpg  = 1'b0;
                    e_path = 1'b0;
                end else if (m_t < 3 + m_run_len + ORA_LAT) begin
                    e_path = 1'b0;
                end else begin
                    e_done = 1'b1;
                end
            end
            checkOutput("busy", int'(busy), (m_t >= 0) ? 1 : 0);
            checkOutput("grant", int'(grant), e_grant);
            checkOutput("cut_sel", int'(cut_sel), m_sel);
            checkOutput("tpg_reset", int'(tpg_reset), int'(e_tpg));
            checkOutput("path_rst", int'(path_rst), int'(e_path));
            checkOutput("done", int'(done), int'(e_done));
            checkOutput("fail_map", int'(fail_map), int'(m_fail));
            if (e_done) begin
                checkOutput("done_id", int'(done_id), m_win);
            end
            if (e_done || m_t < 0) begin
                checkOutput("err_count", int'(err_count), m_err);
            end
        end
    end

    task automatic waitDone(input int limit, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < limit && !seen; k++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) checkOutput("done_wait", 0, 1);
    endtask

    task automatic waitRun(input int limit);
        int guard;
        guard = 0;
        while (tpg_reset !== 1'b0 && guard < limit) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= limit) checkOutput("run_wait", 0, 1);
    endtask

    task automatic requestSlot(input logic [3:0] reqv);
        int guard;
        @(negedge clk);
        req   = reqv;
        guard = 0;
        while (grant == 4'b0000 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) checkOutput("grant_wait", 0, 1);
        req = 4'b0000;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One complete session: oraMode 0 = clean, 1 = mismatch every sweep and
    // drain cycle, 2 = mismatch only in the drain cycles
    task automatic applyStimulus(input logic [3:0] reqv, input int runLen, input int oraMode,
                                 output int doneId, output int errSeen, output int grantSeen);
        bit seen;
        requestSlot(reqv);
        waitRun(20);
        ora_res = (oraMode == 1);
        repeat (runLen - 1) @(negedge clk);
        tpg_end = 1'b1;
        @(negedge clk);
        tpg_end = 1'b0;
        ora_res = (oraMode != 0);
        repeat (ORA_LAT) @(negedge clk);
        ora_res = 1'b0;
        waitDone(5, seen);
        doneId    = int'(done_id);
        errSeen   = int'(err_count);
        grantSeen = int'(grant);
        @(negedge clk);
    endtask

    initial begin
        int id;
        int err;
        int gnt;
        int prev_cyc;
        int start_cyc;
        bit seen;
        int exp_ids[5];
        exp_ids = '{0, 1, 2, 3, 0};
        total   = 0;
        bad     = 0;
        cyc     = 0;
        m_valid = 1'b0;
        rst     = 1'b1;
        req     = 4'b0000;
        tpg_end = 1'b0;
        ora_res = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("[TB] reset values");
        checkOutput("rst_grant", int'(grant), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_tpg_reset", int'(tpg_reset), 1);
        checkOutput("rst_path_rst", int'(path_rst), 1);
        checkOutput("rst_err", int'(err_count), 0);

        $display("[TB] T2 all slots requesting");
        @(negedge clk);
        req      = 4'b1111;
        tpg_end  = 1'b1;
        prev_cyc = 0;
        for (int n = 0; n < 5; n++) begin
            waitDone(30, seen);
            if (seen) begin
                checkOutput("t2_done_id", int'(done_id), exp_ids[n]);
                if (n > 0) checkOutput("t2_gap_ge7", ((cyc - prev_cyc) >= 7) ? 1 : 0, 1);
                prev_cyc = cyc;
            end
            if (n == 4) req = 4'b0000;
            @(negedge clk);
        end
        tpg_end = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("t2_idle_busy", int'(busy), 0);

        $display("[TB] T1 slot 2 clean");
        applyStimulus(4'b0100, 32, 0, id, err, gnt);
        checkOutput("t1_done_id", id, 2);
        checkOutput("t1_err", err, 0);
        checkOutput("t1_grant", gnt, 4);
        checkOutput("t1_cut_sel", int'(cut_sel), 2);
        checkOutput("t1_fail_map", int'(fail_map), 0);

        $display("[TB] T3 slot 1 saturating");
        applyStimulus(4'b0010, 38, 1, id, err, gnt);
        checkOutput("t3_done_id", id, 1);
        checkOutput("t3_err", err, 31);
        checkOutput("t3_fail_map", int'(fail_map), 4'b0010);

        $display("[TB] T4 slot 3 drain-only mismatches");
        applyStimulus(4'b1000, 10, 2, id, err, gnt);
        checkOutput("t4_done_id", id, 3);
        checkOutput("t4_err", err, 2);
        checkOutput("t4_fail_map", int'(fail_map), 4'b1010);

        $display("[TB] T5 sweep that never ends");
        requestSlot(4'b0001);
        waitRun(20);
        start_cyc = cyc;
`ifdef SCHED_TIMEOUT_EN
        waitDone(300, seen);
        checkOutput("t5_run_plus_drain", cyc - start_cyc, WD_RUN + ORA_LAT);
        checkOutput("t5_err", int'(err_count), 31);
        @(negedge clk);
        checkOutput("t5_fail_map", int'(fail_map), 4'b1011);
`else
        repeat (200) @(negedge clk);
        checkOutput("t5_busy_held", int'(busy), 1);
        checkOutput("t5_still_run", int'(tpg_reset), 0);
        checkOutput("t5_no_done", int'(done), 0);
        pulseReset();
`endif

        $display("[TB] T6 reset in the middle of a sweep");
        requestSlot(4'b0010);
        waitRun(20);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("t6_grant", int'(grant), 0);
        checkOutput("t6_cut_sel", int'(cut_sel), 0);
        checkOutput("t6_busy", int'(busy), 0);
        checkOutput("t6_tpg_reset", int'(tpg_reset), 1);
        checkOutput("t6_path_rst", int'(path_rst), 1);
        checkOutput("t6_fail_map", int'(fail_map), 0);
        checkOutput("t6_err", int'(err_count), 0);
        applyStimulus(4'b0001, 5, 0, id, err, gnt);
        checkOutput("t6_done_id", id, 0);
        checkOutput("t6_err_after", err, 0);
        checkOutput("t6_grant_after", gnt, 1);
        checkOutput("t6_fail_after", int'(fail_map), 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case a scenario wedges beyond its own bounded waits
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got %0d cycles expected fewer", cyc);
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
